// File: rtl/weight_serializer_pkg.sv
// Shared definitions for the weight byte loader/serializer pair: byte count and FSM encoding.
package weight_serializer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Both ends must agree on how many bytes a packed weight vector occupies.
   function automatic int num_bytes(input int n, input int size);
      return (n * size * size + 7) / 8;
   endfunction

endpackage

// File: rtl/weight_byte_index_counter.sv
// Byte index for the weight dump: cleared on start, advanced per accepted byte, saturating at the last byte.
// Registered index and last flag; no handshake of its own.
module weight_byte_index_counter
   import weight_serializer_pkg::*;
#(
   parameter int IdxWidth = 4,
   parameter int NumBytes = 5
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                clear_i,
   input  logic                incr_i,
   output logic [IdxWidth-1:0] idx_o,
   output logic                is_last_o
);

   localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumBytes - 1);

   logic [IdxWidth-1:0] idx_q, idx_d;

   always_comb begin
      idx_d = idx_q;
      if (clear_i) begin
         idx_d = '0;
      end else if (incr_i && (idx_q != LastIdx)) begin
         idx_d = idx_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         idx_q <= '0;
      end else begin
         idx_q <= idx_d;
      end
   end

   assign idx_o     = idx_q;
   assign is_last_o = (idx_q == LastIdx);

endmodule

// File: rtl/weight_serializer.sv
// Snapshots a packed weight vector on start and streams it out little-endian, one byte per valid/ready handshake.
// First byte valid the cycle after start; holds the byte under backpressure; done_o pulses the cycle after the last byte.
module weight_serializer
   import weight_serializer_pkg::*;
#(
   parameter int N    = 10,
   parameter int Size = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [N*Size*Size-1:0] weights_i,
   output logic [7:0]            data_o,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic                  last_o,
   output logic                  busy_o,
   output logic                  done_o
);

   localparam int RawBits  = N * Size * Size;
   localparam int NumBytes = num_bytes(N, Size);
   localparam int IdxWidth = $clog2(NumBytes) + 1;
   localparam int SnapBits = NumBytes * 8;

   state_e              state_q, state_d;
   logic [SnapBits-1:0] snap_q, snap_d;
   logic [IdxWidth-1:0] idx;
   logic                is_last;
   logic                start_acc;
   logic                xfer;
   logic [7:0]          byte_sel;

   weight_byte_index_counter #(
      .IdxWidth (IdxWidth),
      .NumBytes (NumBytes)
   ) u_idx (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clear_i   (start_acc),
      .incr_i    (xfer),
      .idx_o     (idx),
      .is_last_o (is_last)
   );

   always_comb begin
      state_d   = state_q;
      snap_d    = snap_q;
      start_acc = 1'b0;
      xfer      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               start_acc             = 1'b1;
               // Pad bits above the raw vector stay zero so the final byte is clean.
               snap_d                = '0;
               snap_d[RawBits-1:0]   = weights_i;
               state_d               = ST_SEND;
            end
         end
         ST_SEND: begin
            if (ready_i) begin
               xfer = 1'b1;
               if (is_last) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         snap_q  <= '0;
      end else begin
         state_q <= state_d;
         snap_q  <= snap_d;
      end
   end

   always_comb begin
      byte_sel = '0;
      for (int k = 0; k < NumBytes; k++) begin
         if (idx == IdxWidth'(k)) begin
            byte_sel = snap_q[8*k +: 8];
         end
      end
   end

   // Everything below decodes flops only, so ready_i never reaches valid_o combinationally.
   assign valid_o = (state_q == ST_SEND);
   assign data_o  = valid_o ? byte_sel : 8'h00;
   assign last_o  = valid_o & is_last;
   assign busy_o  = valid_o;
   assign done_o  = (state_q == ST_DONE);

endmodule

// File: tb/tb_weight_serializer.sv
// Directed and randomized dumps of weight_serializer instances checked against a byte-queue model.
module tb_weight_serializer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Instance A: N=10, Size=2 -> 40 bits, 5 bytes
   logic        sa, ra, va, la, ba, dna;
   logic [39:0] wa;
   logic [7:0]  da;
   // Instance B: N=3, Size=2 -> 12 bits, 2 bytes
   logic        sb, rb, vb, lb, bb, dnb;
   logic [11:0] wb;
   logic [7:0]  db;
   // Instance C: N=1, Size=2 -> 4 bits, 1 byte
   logic        sc, rc, vc, lc, bc, dnc;
   logic [3:0]  wc;
   logic [7:0]  dc;

   weight_serializer #(.N(10), .Size(2)) dut_a (
      .clk_i(clk), .rst_i(rst), .start_i(sa), .weights_i(wa), .data_o(da),
      .valid_o(va), .ready_i(ra), .last_o(la), .busy_o(ba), .done_o(dna));
   weight_serializer #(.N(3), .Size(2)) dut_b (
      .clk_i(clk), .rst_i(rst), .start_i(sb), .weights_i(wb), .data_o(db),
      .valid_o(vb), .ready_i(rb), .last_o(lb), .busy_o(bb), .done_o(dnb));
   weight_serializer #(.N(1), .Size(2)) dut_c (
      .clk_i(clk), .rst_i(rst), .start_i(sc), .weights_i(wc), .data_o(dc),
      .valid_o(vc), .ready_i(rc), .last_o(lc), .busy_o(bc), .done_o(dnc));

   logic [7:0] exp_q[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Expected byte stream: bit b of the vector lands in byte b/8, bit b%8; bits beyond raw_bits read as 0.
   task automatic model(input logic [63:0] w, input int raw_bits);
      logic [63:0] m;
      int nb;
      exp_q.delete();
      nb = (raw_bits + 7) / 8;
      m  = w & ((64'd1 << raw_bits) - 64'd1);
      for (int k = 0; k < nb; k++) begin
         exp_q.push_back(8'((m >> (8 * k)) & 64'hFF));
      end
   endtask

   // Called at a negedge in IDLE; returns at the negedge of the IDLE cycle after done_o.
   // mode 0: ready always high, 1: ready 1,0,0 repeating, 2: random ready.
   task automatic dump_a(input logic [39:0] w, input int mode, input bit disturb);
      int cyc;
      model({24'd0, w}, 40);
      wa = w;
      sa = 1'b1;
      @(negedge clk);
      sa = 1'b0;
      wa = ~w;
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 100) begin
         case (mode)
            0:       ra = 1'b1;
            1:       ra = ((cyc % 3) == 0);
            default: ra = 1'($urandom_range(0, 1));
         endcase
         if (disturb && cyc == 2) begin
            sa = 1'b1;
            wa = {8'($urandom), 32'($urandom)};
         end else begin
            sa = 1'b0;
         end
         chk("send_valid", va, 1);
         chk("send_busy", ba, 1);
         chk("send_no_done", dna, 0);
         chk("send_data", da, exp_q[0]);
         chk("send_last", la, exp_q.size() == 1);
         if (ra) void'(exp_q.pop_front());
         cyc++;
         @(negedge clk);
      end
      sa = 1'b0;
      ra = 1'b0;
      chk("bytes_left", exp_q.size(), 0);
      chk("done_pulse", dna, 1);
      chk("done_valid", va, 0);
      chk("done_busy", ba, 0);
      @(negedge clk);
      chk("idle_done", dna, 0);
      chk("idle_valid", va, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [39:0] w;
      sa = 0; ra = 0; wa = '0;
      sb = 0; rb = 1; wb = '0;
      sc = 0; rc = 1; wc = '0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_valid", va, 0);
      chk("rst_data", da, 0);
      chk("rst_last", la, 0);
      chk("rst_busy", ba, 0);
      chk("rst_done", dna, 0);
      chk("rst_valid_b", vb, 0);
      rst = 1'b0;
      @(negedge clk);

      // Odd widths: pad bits of the final byte are zero; single-byte vector is last immediately.
      wb = 12'hFFF; sb = 1'b1;
      wc = 4'hA;    sc = 1'b1;
      @(negedge clk);
      sb = 1'b0; sc = 1'b0;
      chk("b_byte0", {vb, lb, db}, {1'b1, 1'b0, 8'hFF});
      chk("c_byte0", {vc, lc, dc}, {1'b1, 1'b1, 8'h0A});
      @(negedge clk);
      chk("b_byte1", {vb, lb, db}, {1'b1, 1'b1, 8'h0F});
      chk("c_done", {vc, bc, dnc}, {1'b0, 1'b0, 1'b1});
      @(negedge clk);
      chk("b_done", {vb, bb, dnb}, {1'b0, 1'b0, 1'b1});
      chk("c_idle", dnc, 0);
      @(negedge clk);
      chk("b_idle", dnb, 0);

      // Directed vector, full throughput then backpressure; consecutive calls are back-to-back.
      dump_a(40'h12_3456_789A, 0, 1'b0);
      dump_a(40'h12_3456_789A, 1, 1'b0);

      // Start and new weights during SEND are ignored; the new value dumps on the next start.
      dump_a({8'($urandom), 32'($urandom)}, 0, 1'b1);
      dump_a(wa, 2, 1'b0);

      for (int i = 0; i < 6; i++) begin
         dump_a({8'($urandom), 32'($urandom)}, 2, 1'b0);
      end

      // Reset while the third byte is presented.
      w  = {8'($urandom), 32'($urandom)};
      model({24'd0, w}, 40);
      wa = w; sa = 1'b1;
      @(negedge clk);
      sa = 1'b0; ra = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_data", da, exp_q[2]);
      rst = 1'b1;
      #1;
      chk("async_valid", va, 0);
      chk("async_busy", ba, 0);
      chk("async_done", dna, 0);
      chk("async_last", la, 0);
      ra = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_done", dna, 0);
      dump_a(w, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
